// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// master: fetch side (issues requests); slave: memory side (acknowledges them).
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, instruction-memory request
// sequencing, one-entry stall buffer and the registered IF/ID payload.
// States: IDLE (one cycle after reset), REQ (fetching), HOLD (fetched word
// parked while decode stalls), DRAIN (waiting out a request made stale by a
// redirect).
// Optional feature: define IF_ALIGN_CHECK_EN to report misaligned redirect
// targets on misalign_fault. Without it misalign_fault is tied low. Target
// bits [1:0] are forced to 00 in both builds.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  instr_fetch_if.master        imem,
  output logic                 if_valid,
  output logic [31:0]          if_instr,
  output logic [31:0]          if_pc,
  output logic [31:0]          fetch_pc,
  output logic                 misalign_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // State and datapath registers
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_fault;

  // Next-state values
  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_pend_next;
  logic [31:0] w_buf_instr_next;
  logic [31:0] w_buf_pc_next;
  logic        w_if_valid_next;
  logic [31:0] w_if_instr_next;
  logic [31:0] w_if_pc_next;
  logic        w_fault_next;

  // Helpers
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;
  logic        w_misaligned;

  // Redirect target with the low two bits masked off; wraps modulo 2^32
  assign w_target     = {redirect_pc[31:2], redirect_pc[1:0] & 2'b00};
  assign w_pc_inc     = r_pc + 32'd4;
  assign w_misaligned = redirect && (redirect_pc[1:0] != 2'b00);

  // Next-state and datapath decisions
  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_pend_next      = r_pend;
    w_buf_instr_next = r_buf_instr;
    w_buf_pc_next    = r_buf_pc;
    w_if_valid_next  = r_if_valid;
    w_if_instr_next  = r_if_instr;
    w_if_pc_next     = r_if_pc;

    // Baseline output behaviour: a redirect always kills the payload,
    // otherwise a stall holds it and a free cycle shows a bubble. The
    // delivery cases below override this.
    if (redirect || !stall) begin
      w_if_valid_next = 1'b0;
      w_if_instr_next = NOP_INSTR;
    end

    case (r_state)
      IDLE: begin
        // No request yet, so any stray ack is ignored here
        w_state_next = REQ;
        if (redirect) begin
          w_pc_next = w_target;
        end
      end

      REQ: begin
        if (imem.imem_ack) begin
          if (redirect) begin
            // Fetched word is on the wrong path: drop it, restart at target
            w_pc_next = w_target;
          end else if (stall) begin
            // Decode busy: park the word and keep the current payload
            w_buf_instr_next = imem.imem_rdata;
            w_buf_pc_next    = w_pc_inc;
            w_pc_next        = w_pc_inc;
            w_state_next     = HOLD;
          end else begin
            w_if_valid_next = 1'b1;
            w_if_instr_next = imem.imem_rdata;
            w_if_pc_next    = w_pc_inc;
            w_pc_next       = w_pc_inc;
          end
        end else if (redirect) begin
          // Request still in flight: remember the target and let it finish
          w_pend_next  = w_target;
          w_state_next = DRAIN;
        end
      end

      HOLD: begin
        if (redirect) begin
          w_pc_next    = w_target;
          w_state_next = REQ;
        end else if (!stall) begin
          w_if_valid_next = 1'b1;
          w_if_instr_next = r_buf_instr;
          w_if_pc_next    = r_buf_pc;
          w_state_next    = REQ;
        end
      end

      DRAIN: begin
        if (imem.imem_ack) begin
          // Stale response is discarded; newest target wins
          w_pc_next    = redirect ? w_target : r_pend;
          w_state_next = REQ;
        end else if (redirect) begin
          w_pend_next = w_target;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

`ifdef IF_ALIGN_CHECK_EN
  // Flag a misaligned redirect target for one cycle
  always_comb begin
    w_fault_next = w_misaligned;
  end
`else
  // Alignment reporting disabled; target is still silently aligned
  always_comb begin
    w_fault_next = 1'b0 & w_misaligned;
  end
`endif

  // State register update with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_pend      <= 32'd0;
      r_buf_instr <= 32'd0;
      r_buf_pc    <= 32'd0;
      r_if_valid  <= 1'b0;
      r_if_instr  <= NOP_INSTR;
      r_if_pc     <= 32'd0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_pend      <= w_pend_next;
      r_buf_instr <= w_buf_instr_next;
      r_buf_pc    <= w_buf_pc_next;
      r_if_valid  <= w_if_valid_next;
      r_if_instr  <= w_if_instr_next;
      r_if_pc     <= w_if_pc_next;
      r_fault     <= w_fault_next;
    end
  end

  // Request is live only while fetching or draining; address is the PC
  assign imem.imem_req  = (r_state == REQ) || (r_state == DRAIN);
  assign imem.imem_addr = r_pc;

  assign fetch_pc       = r_pc;
  assign if_valid       = r_if_valid;
  assign if_instr       = r_if_instr;
  assign if_pc          = r_if_pc;
  assign misalign_fault = r_fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios with a scoreboard of expected
// IF/ID deliveries, popped by a monitor whenever decode accepts a word.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        a_if_valid;
  logic [31:0] a_if_instr;
  logic [31:0] a_if_pc;
  logic [31:0] a_fetch_pc;
  logic        a_fault;

  logic        b_stall;
  logic        b_redirect;
  logic [31:0] b_redirect_pc;
  logic        b_if_valid;
  logic [31:0] b_if_instr;
  logic [31:0] b_if_pc;
  logic [31:0] b_fetch_pc;
  logic        b_fault;

  int   lat;
  logic force_ack;
  int   wait_cnt;

  int n_checks;
  int n_pass;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  instr_fetch_if bus_a ();
  instr_fetch_if bus_b ();

  instr_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem           (bus_a),
    .if_valid       (a_if_valid),
    .if_instr       (a_if_instr),
    .if_pc          (a_if_pc),
    .fetch_pc       (a_fetch_pc),
    .misalign_fault (a_fault)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_wrap (
    .clk            (clk),
    .rst            (rst),
    .stall          (b_stall),
    .redirect       (b_redirect),
    .redirect_pc    (b_redirect_pc),
    .imem           (bus_b),
    .if_valid       (b_if_valid),
    .if_instr       (b_if_instr),
    .if_pc          (b_if_pc),
    .fetch_pc       (b_fetch_pc),
    .misalign_fault (b_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model A: programmable latency, optional forced ack, rdata = addr
  assign bus_a.imem_ack   = force_ack | (bus_a.imem_req && (wait_cnt >= lat));
  assign bus_a.imem_rdata = bus_a.imem_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (bus_a.imem_req && !bus_a.imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Memory model B: zero-wait, rdata = addr
  assign bus_b.imem_ack   = bus_b.imem_req;
  assign bus_b.imem_rdata = bus_b.imem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("check %s: got %h", name, act);
    end else begin
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: decode accepts a word when valid and not stalled
  always @(negedge clk) begin
    if (!rst && a_if_valid && !stall) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL deliver_unexpected: got instr=%h pc=%h, required no delivery",
                 a_if_instr, a_if_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (a_if_instr === mon_e.instr && a_if_pc === mon_e.pc) begin
          n_pass++;
          $display("deliver instr=%h pc=%h", a_if_instr, a_if_pc);
        end else begin
          $display("FAIL deliver: got instr=%h pc=%h, required instr=%h pc=%h",
                   a_if_instr, a_if_pc, mon_e.instr, mon_e.pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    logic exp_fault;
`ifdef IF_ALIGN_CHECK_EN
    exp_fault = 1'b1;
`else
    exp_fault = 1'b0;
`endif
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    b_stall = 1'b0;
    b_redirect = 1'b0;
    b_redirect_pc = 32'd0;
    lat = 0;
    force_ack = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_valid", {31'd0, a_if_valid}, 32'd0);
    chk("rst_instr", a_if_instr, NOP);
    chk("rst_pc", a_if_pc, 32'd0);
    chk("rst_req", {31'd0, bus_a.imem_req}, 32'd0);
    chk("rst_fetch_pc", a_fetch_pc, 32'd0);
    chk("rst_fault", {31'd0, a_fault}, 32'd0);
    chk("rst_wrap_fetch_pc", b_fetch_pc, 32'hFFFF_FFFC);

    // Zero-wait streaming
    rst = 1'b0;
    chk("idle_req", {31'd0, bus_a.imem_req}, 32'd0);
    tick();                                   // P1: first REQ
    chk("req1_req", {31'd0, bus_a.imem_req}, 32'd1);
    chk("req1_addr", bus_a.imem_addr, 32'd0);
    chk("req1_valid", {31'd0, a_if_valid}, 32'd0);
    chk("wrap_addr1", bus_b.imem_addr, 32'hFFFF_FFFC);
    for (int k = 0; k < 5; k++) push(32'(k * 4), 32'(k * 4 + 4));
    tick();                                   // P2: first delivery
    chk("cycle3_valid", {31'd0, a_if_valid}, 32'd1);
    chk("stream_addr", bus_a.imem_addr, 32'h4);
    chk("wrap_addr2", bus_b.imem_addr, 32'h0);
    chk("wrap_if_pc", b_if_pc, 32'h0);
    chk("wrap_if_instr", b_if_instr, 32'hFFFF_FFFC);
    tick();
    tick();
    tick();                                   // P5: addr 0x10 acked this cycle
    chk("pre_stall_addr", bus_a.imem_addr, 32'h10);
    chk("pre_stall_instr", a_if_instr, 32'hC);
    stall = 1'b1;
    tick();                                   // P6: HOLD
    chk("hold_req", {31'd0, bus_a.imem_req}, 32'd0);
    chk("hold_instr", a_if_instr, 32'hC);
    chk("hold_if_pc", a_if_pc, 32'h10);
    chk("hold_fetch_pc", a_fetch_pc, 32'h14);
    tick();
    chk("hold_instr2", a_if_instr, 32'hC);
    tick();                                   // P8
    stall = 1'b0;
    chk("hold_req3", {31'd0, bus_a.imem_req}, 32'd0);
    tick();                                   // P9: buffer released
    chk("release_instr", a_if_instr, 32'h10);
    chk("release_pc", a_if_pc, 32'h14);
    chk("release_addr", bus_a.imem_addr, 32'h14);

    // Redirect during slow request
    lat = 3;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();                                   // P10: DRAIN
    redirect = 1'b0;
    chk("drain_addr0", bus_a.imem_addr, 32'h14);
    chk("drain_valid0", {31'd0, a_if_valid}, 32'd0);
    chk("drain_instr0", a_if_instr, NOP);
    tick();
    chk("drain_addr1", bus_a.imem_addr, 32'h14);
    tick();
    chk("drain_addr2", bus_a.imem_addr, 32'h14);
    chk("drain_valid2", {31'd0, a_if_valid}, 32'd0);
    tick();                                   // P13: restarted at target
    chk("redir_addr", bus_a.imem_addr, 32'h100);
    chk("redir_no_old_word", {31'd0, a_if_valid}, 32'd0);
    lat = 0;
    tick();                                   // P14
    chk("redir_instr", a_if_instr, 32'h100);
    chk("redir_if_pc", a_if_pc, 32'h104);

    // Redirect while stalled
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();                                   // P15
    redirect = 1'b0;
    chk("rs_valid", {31'd0, a_if_valid}, 32'd0);
    chk("rs_instr", a_if_instr, NOP);
    chk("rs_fetch_pc", a_fetch_pc, 32'h200);
    chk("rs_fault", {31'd0, a_fault}, 32'd0);
    tick();                                   // P16: HOLD with 0x200 parked
    chk("h2_req", {31'd0, bus_a.imem_req}, 32'd0);
    chk("h2_fetch_pc", a_fetch_pc, 32'h204);

    // Misaligned redirect out of HOLD
    redirect = 1'b1;
    redirect_pc = 32'h302;
    tick();                                   // P17
    redirect = 1'b0;
    stall = 1'b0;
    chk("mis_addr", bus_a.imem_addr, 32'h300);
    chk("mis_valid", {31'd0, a_if_valid}, 32'd0);
    chk("mis_fault", {31'd0, a_fault}, {31'd0, exp_fault});
    push(32'h300, 32'h304);
    tick();                                   // P18
    chk("mis_fault_pulse", {31'd0, a_fault}, 32'd0);
    chk("mis_addr2", bus_a.imem_addr, 32'h304);
    lat = 3;
    tick();                                   // P19: waiting, bubble
    chk("wait_valid", {31'd0, a_if_valid}, 32'd0);
    chk("wait_addr", bus_a.imem_addr, 32'h304);

    // Reset mid-request
    rst = 1'b1;
    #1;
    chk("midrst_req", {31'd0, bus_a.imem_req}, 32'd0);
    chk("midrst_fetch_pc", a_fetch_pc, 32'd0);
    chk("midrst_instr", a_if_instr, NOP);
    tick();
    tick();
    lat = 0;
    force_ack = 1'b1;
    rst = 1'b0;                               // IDLE with stray ack
    tick();                                   // first REQ
    force_ack = 1'b0;
    chk("stray_addr", bus_a.imem_addr, 32'h0);
    chk("stray_valid", {31'd0, a_if_valid}, 32'd0);
    push(32'h0, 32'h4);
    tick();
    chk("post_rst_addr", bus_a.imem_addr, 32'h4);
    tick();
    stall = 1'b1;
    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, SHALL set the instruction driven on if_instr when if_valid=0.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 stall  input  1  SHALL indicate that decode cannot accept a new instruction (hazard hold).
REQ-006 redirect  input  1  SHALL indicate a taken branch or jump.
REQ-007 redirect_pc  input  32  SHALL carry the branch or jump target.
REQ-008 imem_req  output  1  SHALL be the instruction-memory request.
REQ-009 imem_addr  output  32  SHALL be the request address, equal to pc_q.
REQ-010 imem_ack  input  1  SHALL indicate response completion; it is valid only while imem_req=1 and may be asserted in the same cycle as the request.
REQ-011 imem_rdata  input  32  SHALL carry the instruction word, valid when imem_ack=1.
REQ-012 if_valid, if_instr[31:0], if_pc[31:0]  outputs SHALL be the registered IF/ID payload; if_pc SHALL be the fetched instruction's address + 4.
REQ-013 fetch_pc  output  32  SHALL equal pc_q.
REQ-014 misalign_fault  output  1  SHALL be the alignment error pulse (see Configuration).

Function
REQ-015 The block SHALL implement four states: IDLE, REQ, HOLD and DRAIN; imem_req SHALL be 1 only in REQ and DRAIN.
REQ-016 imem_addr SHALL remain stable while imem_req=1 and imem_ack=0; pc_q SHALL NOT change during that time.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to REQ (or load redirect_pc and go to REQ if redirect=1).
REQ-018 In REQ, with ack=1, stall=0 and redirect=0: load if_instr<=imem_rdata, if_pc<=pc_q+4, if_valid<=1, pc_q<=pc_q+4, and stay in REQ; zero-wait memory SHALL sustain 1 instruction/cycle.
REQ-019 In REQ, with ack=1, stall=1 and redirect=0: capture {imem_rdata, pc_q+4} in a 1-entry buffer, set pc_q<=pc_q+4, and go to HOLD; outputs SHALL hold.
REQ-020 In HOLD: when stall=0, move the buffer to the outputs (if_valid<=1) and go to REQ; when stall=1, hold.
REQ-021 In REQ, with ack=0 and redirect=1: store redirect_pc in pend_q and go to DRAIN; the outstanding request SHALL be completed.
REQ-022 In DRAIN: on ack, discard rdata, set pc_q<=pend_q, and go to REQ; a further redirect in DRAIN SHALL overwrite pend_q.
REQ-023 In REQ, with ack=1 and redirect=1: discard rdata, set pc_q<=redirect_pc, and stay in REQ.
REQ-024 In HOLD, with redirect=1: discard the buffer, set pc_q<=redirect_pc, and go to REQ.
REQ-025 Redirect SHALL take priority over stall: the next cycle SHALL show if_valid=0 and if_instr=NOP_INSTR.
REQ-026 With stall=0 and no instruction delivered, the next cycle SHALL show if_valid=0 and if_instr=NOP_INSTR; with stall=1 (and no redirect), all if_* outputs SHALL hold.
REQ-027 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

Reset
REQ-028 While rst=1, the block SHALL set state=IDLE, pc_q=RESET_PC, pend_q=0, buffer=0, if_valid=0, if_instr=NOP_INSTR, if_pc=0, misalign_fault=0, and imem_req=0.
REQ-029 Reset asserted mid-request SHALL abandon the transaction; an imem_ack received before the first REQ cycle SHALL be ignored.

Configuration
REQ-030 With IF_ALIGN_CHECK_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL pulse misalign_fault=1 for one cycle, and the target SHALL be used with bits [1:0] forced to 00.
REQ-031 Without IF_ALIGN_CHECK_EN, misalign_fault SHALL be tied to 0 and bits [1:0] SHALL still be forced to 00.

Verification
REQ-032 Scenario: reset, ack tied 1, rdata=addr -> if_valid=1 from cycle 3; if_instr = 0, 4, 8, ... one per cycle; if_pc = 4, 8, 12, ...
REQ-033 Scenario: stall=1 for 3 cycles coincident with the ack of addr 0x10 -> outputs frozen, imem_req=0 in HOLD; after release if_instr=mem[0x10], if_pc=0x14; next request addr=0x14.
REQ-034 Scenario: 3-cycle ack latency, redirect to 0x100 in the first wait cycle -> imem_addr stays at old value until ack, response dropped, next imem_addr=0x100, no if_valid pulse for the old word.
REQ-035 Scenario: redirect to 0x200 while stall=1 -> next cycle if_valid=0, if_instr=NOP_INSTR; fetch_pc=0x200.
REQ-036 Scenario: RESET_PC=32'hFFFF_FFFC, ack=1 -> second imem_addr=0x0, if_pc of first instruction=0x0.
REQ-037 Scenario: with IF_ALIGN_CHECK_EN, redirect_pc=0x302 -> misalign_fault=1 for one cycle, next imem_addr=0x300; without the macro -> misalign_fault=0, next imem_addr=0x300.
